ebi_write_arbiter: RTL and testbench
====================================

EBI_WRITE_ARBITER -- requirements
Module: ebi_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: EBI write buffer entries, power of two, 2 to 16.
REQ-002 Parameter REG_BASE, default 16'hF000: base of 16-word control-register window; addresses REG_BASE to REG_BASE+15 are register writes, all others are memory writes.
REQ-003 Parameter STARVE_LIMIT, default 8: cycles a buffered memory write may wait before it is forced onto the memory port.
REQ-004 Ports: clk in 1, single system clock; all logic on rising edge.
REQ-005 Ports: reset in 1, asynchronous, active-low.
REQ-006 Ports: ebi_address in 16, ebi_data in 16, ebi_data_ready in 1: EBI write from the bus decoder; data_ready is a one-cycle pulse.
REQ-007 Ports: rd_req in 1, rd_addr in 16: renderer read request, level, held until granted.
REQ-008 Ports: rd_gnt out 1, rd_valid out 1, rd_data out 16: grant pulse, read-return pulse, read data.
REQ-009 Ports: mem_addr out 16, mem_wdata out 16, mem_we out 1, mem_re out 1, mem_rdata in 16: shared single-port memory; read data returns one cycle after mem_re.
REQ-010 Ports: reg_wr_en out 1, reg_addr out 4, reg_wdata out 16: control-register write strobe.
REQ-011 Ports: overflow out 1 (sticky), overflow_clr in 1; write_count out 16, drop_count out 8.

Function
REQ-012 On ebi_data_ready, {ebi_address, ebi_data} is pushed at that clock edge; the entry is eligible for pop on the next cycle.
REQ-013 FSM states: IDLE, READ, WRITE; the arbiter makes one decision per cycle; every mem_* and reg_* output is registered one cycle after the decision.
REQ-014 Priority, highest first: (a) head is a memory write and has waited STARVE_LIMIT cycles -> WRITE; (b) rd_req -> READ; (c) FIFO non-empty with memory head -> WRITE; (d) else IDLE.
REQ-015 A register-region head pops in any state without using the memory port; reg_wr_en pulses for one cycle with reg_addr = address[3:0] and reg_wdata = data; the memory decision for that cycle is unaffected.
REQ-016 READ: rd_gnt pulses in the decision cycle; the next cycle drives mem_re=1 and mem_addr=rd_addr; the cycle after that, rd_valid=1 and rd_data=mem_rdata.
REQ-017 WRITE: the head pops; the next cycle drives mem_we=1 with mem_addr and mem_wdata from the entry, for exactly one cycle.
REQ-018 mem_we and mem_re are never high together; rd_gnt is low in any cycle a forced write wins.
REQ-019 The starvation counter counts cycles the head memory entry is present and not popped, resets on pop, and saturates at STARVE_LIMIT.
REQ-020 Push with FIFO full and no pop that cycle: entry dropped, overflow set; push while full with a pop in the same cycle is accepted.
REQ-021 overflow clears on overflow_clr unless a drop occurs in the same cycle, in which case it stays set.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; entries leave in strict push order.

Reset
REQ-023 Reset asserted: FIFO emptied, FSM to IDLE, starvation counter 0, and all outputs 0 (rd_gnt, rd_valid, rd_data, mem_*, reg_*, overflow, write_count, drop_count).
REQ-024 Reset asserted mid-read or mid-write: the pending rd_valid or mem_we is cancelled; buffered entries are discarded.

Configuration
REQ-025 Macro EBI_ARB_STATS_EN defined: write_count increments once per mem_we or reg_wr_en (16-bit, wraps); drop_count increments per dropped push (8-bit, saturates at 255).
REQ-026 Macro EBI_ARB_STATS_EN undefined: write_count and drop_count are tied to 0 and no counter logic exists; all other behaviour is identical.

Verification
REQ-027 Reset held 3 cycles, then released -> all outputs 0, FIFO empty.
REQ-028 Push addr 0x0005, data 0x0032, rd_req=0 -> 2 cycles later mem_we=1, mem_addr=0x0005, mem_wdata=0x0032 for one cycle.
REQ-029 rd_req held, rd_addr=0x0100, mem_rdata=0xBEEF, then push addr 0xF003, data 0x001E -> reg_wr_en pulse, reg_addr=3, reg_wdata=0x001E; reads continue with rd_valid and rd_data=0xBEEF.
REQ-030 rd_req held, one push to 0x0010 -> forced write STARVE_LIMIT=8 cycles after push; rd_gnt low that cycle.
REQ-031 rd_req held, 5 pushes to 0x0000-0x0004 on consecutive cycles -> 5th dropped, overflow=1, drop_count=1 (stats on); overflow_clr pulse -> overflow=0.
REQ-032 Push coincident with reset assertion -> no mem_we after release, write_count=0.

Source files
------------

// File: rtl/ebi_write_arbiter.sv
// EBI write buffer plus arbiter sharing one single-port memory between buffered writes and renderer reads.
// Define EBI_ARB_STATS_EN to build the write_count / drop_count statistics counters.
module ebi_write_arbiter #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] REG_BASE     = 16'hF000,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ebi_address,
  input  logic [15:0] ebi_data,
  input  logic        ebi_data_ready,
  input  logic        rd_req,
  input  logic [15:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic        reg_wr_en,
  output logic [3:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [15:0] write_count,
  output logic [7:0]  drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] LAST_PTR   = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  state_t        r_state;

  state_t        w_next;
  logic [31:0]   w_head;
  logic [15:0]   w_head_addr;
  logic          w_head_valid;
  logic          w_in_window;
  logic          w_head_reg;
  logic          w_head_mem;
  logic          w_forced;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_head       = r_fifo[r_rd_ptr];
  assign w_head_addr  = w_head[31:16];
  assign w_head_valid = (r_count != '0);
  assign w_in_window  = ({1'b0, w_head_addr} >= {1'b0, REG_BASE}) &&
                        ({1'b0, w_head_addr} <= ({1'b0, REG_BASE} + 17'd15));
  assign w_head_reg   = w_head_valid && w_in_window;
  assign w_head_mem   = w_head_valid && !w_in_window;
  assign w_forced     = w_head_mem && (r_starve >= STARVE_MAX);
  assign w_full       = (r_count == FULL_CNT);

  always_comb begin
    w_next = IDLE;
    if (w_forced)
      w_next = WRITE;
    else if (rd_req)
      w_next = READ;
    else if (w_head_mem)
      w_next = WRITE;
  end

  // Register-window entries drain through the reg port regardless of the memory decision.
  assign w_pop  = w_head_reg || (w_next == WRITE);
  assign w_push = ebi_data_ready && (!w_full || w_pop);
  assign w_drop = ebi_data_ready && w_full && !w_pop;

  assign rd_gnt  = reset && (w_next == READ);
  assign rd_data = rd_valid ? mem_rdata : 16'h0000;

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= {ebi_address, ebi_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_state   <= IDLE;
      rd_valid  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      overflow  <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);

      if (w_pop || !w_head_mem)
        r_starve <= '0;
      else if (r_starve < STARVE_MAX)
        r_starve <= r_starve + SW'(1);

      r_state  <= w_next;
      mem_we   <= (w_next == WRITE);
      mem_re   <= (w_next == READ);
      rd_valid <= (r_state == READ);
      if (w_next == WRITE) begin
        mem_addr  <= w_head_addr;
        mem_wdata <= w_head[15:0];
      end else if (w_next == READ) begin
        mem_addr  <= rd_addr;
      end

      reg_wr_en <= w_head_reg;
      if (w_head_reg) begin
        reg_addr  <= w_head_addr[3:0];
        reg_wdata <= w_head[15:0];
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

`ifdef EBI_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_count <= '0;
      drop_count  <= '0;
    end else begin
      if (mem_we || reg_wr_en)
        write_count <= write_count + 16'd1;
      if (w_drop && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end
`else
  assign write_count = 16'h0000;
  assign drop_count  = 8'h00;
`endif

endmodule

// File: tb/tb_ebi_write_arbiter.sv
// Scoreboard bench for ebi_write_arbiter: directed stimulus queues expected events, a negedge monitor checks them.
module tb_ebi_write_arbiter;

`ifdef EBI_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [15:0] MEM_VALUE = 16'hBEEF;

  logic        clk;
  logic        reset;
  logic [15:0] ebi_address;
  logic [15:0] ebi_data;
  logic        ebi_data_ready;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        reg_wr_en;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        overflow;
  logic        overflow_clr;
  logic [15:0] write_count;
  logic [7:0]  drop_count;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } gnt_t;

  exp_t memQ [$];
  exp_t regQ [$];
  gnt_t gntQ [$];
  int   reQ  [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   memWeCount = 0;
  int   rdValidCount = 0;
  int   p;
  int   base;
  int   weBase;
  logic rdReqLevel;
  exp_t monE;
  gnt_t monG;
  int   monR;

  ebi_write_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ebi_address   (ebi_address),
    .ebi_data      (ebi_data),
    .ebi_data_ready(ebi_data_ready),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .write_count   (write_count),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=present required=absent cycle=%0d", name, cyc);
  endtask

  // One cycle of stimulus, entered and left just after a rising edge.
  task automatic applyStimulus(input logic dr, input logic [15:0] addr, input logic [15:0] data,
                               input logic clr);
    ebi_data_ready = dr;
    ebi_address    = addr;
    ebi_data       = data;
    overflow_clr   = clr;
    rd_req         = rdReqLevel;
    @(posedge clk);
    #1;
    ebi_data_ready = 1'b0;
    overflow_clr   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic idleTo(input int t);
    while (cyc < t) applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe; reset cancels in-flight reads.
  always @(negedge clk) begin
    if (!reset) begin
      gntQ.delete();
      reQ.delete();
    end else begin
      if (mem_we || mem_re)
        checkOutput("memExclusive", 16'(mem_we & mem_re), 16'h0000);
      if (rd_gnt)
        gntQ.push_back('{cyc, rd_addr});
      if (mem_re) begin
        if (gntQ.size() == 0) reportUnexpected("unexpectedRead");
        else begin
          monG = gntQ.pop_front();
          checkOutput("readLatency", 16'(cyc - monG.cyc), 16'd1);
          checkOutput("readAddr", mem_addr, monG.addr);
          reQ.push_back(cyc);
        end
      end
      if (rd_valid) begin
        rdValidCount++;
        if (reQ.size() == 0) reportUnexpected("unexpectedReadData");
        else begin
          monR = reQ.pop_front();
          checkOutput("readDataLatency", 16'(cyc - monR), 16'd1);
          checkOutput("readData", rd_data, MEM_VALUE);
        end
      end
      if (mem_we) begin
        memWeCount++;
        if (memQ.size() == 0) reportUnexpected("unexpectedMemWrite");
        else begin
          monE = memQ.pop_front();
          checkOutput("memWriteAddr", mem_addr, monE.addr);
          checkOutput("memWriteData", mem_wdata, monE.data);
          checkOutput("memWriteCycle", 16'(cyc), 16'(monE.cyc));
        end
      end
      if (reg_wr_en) begin
        if (regQ.size() == 0) reportUnexpected("unexpectedRegWrite");
        else begin
          monE = regQ.pop_front();
          checkOutput("regWriteAddr", {12'h000, reg_addr}, monE.addr);
          checkOutput("regWriteData", reg_wdata, monE.data);
          checkOutput("regWriteCycle", 16'(cyc), 16'(monE.cyc));
        end
      end
    end
  end

  initial begin
    reset          = 1'b0;
    ebi_address    = 16'h0000;
    ebi_data       = 16'h0000;
    ebi_data_ready = 1'b0;
    rd_req         = 1'b0;
    rd_addr        = 16'h0000;
    overflow_clr   = 1'b0;
    mem_rdata      = MEM_VALUE;
    rdReqLevel     = 1'b0;

    // Reset held three cycles, then every output must read zero.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rstRdGnt", 16'(rd_gnt), 16'h0000);
    checkOutput("rstRdValid", 16'(rd_valid), 16'h0000);
    checkOutput("rstRdData", rd_data, 16'h0000);
    checkOutput("rstMemAddr", mem_addr, 16'h0000);
    checkOutput("rstMemWdata", mem_wdata, 16'h0000);
    checkOutput("rstMemWe", 16'(mem_we), 16'h0000);
    checkOutput("rstMemRe", 16'(mem_re), 16'h0000);
    checkOutput("rstRegWrEn", 16'(reg_wr_en), 16'h0000);
    checkOutput("rstRegAddr", {12'h000, reg_addr}, 16'h0000);
    checkOutput("rstRegWdata", reg_wdata, 16'h0000);
    checkOutput("rstOverflow", 16'(overflow), 16'h0000);
    checkOutput("rstWriteCount", write_count, 16'h0000);
    checkOutput("rstDropCount", {8'h00, drop_count}, 16'h0000);
    @(posedge clk); #1;

    // Single memory write with no reads pending: strobe two cycles after the push.
    p = cyc;
    memQ.push_back('{p + 2, 16'h0005, 16'h0032});
    applyStimulus(1'b1, 16'h0005, 16'h0032, 1'b0);
    idleCycles(5);
    @(negedge clk);
    checkOutput("writeCountMem", write_count, STATS ? 16'd1 : 16'd0);
    @(posedge clk); #1;

    // Register write slips between back-to-back reads.
    rd_addr    = 16'h0100;
    rdReqLevel = 1'b1;
    base       = rdValidCount;
    idleCycles(2);
    p = cyc;
    regQ.push_back('{p + 2, 16'h0003, 16'h001E});
    applyStimulus(1'b1, 16'hF003, 16'h001E, 1'b0);
    idleCycles(3);
    rdReqLevel = 1'b0;
    idleCycles(4);
    @(negedge clk);
    checkOutput("readCount", 16'(rdValidCount - base), 16'd6);
    checkOutput("writeCountReg", write_count, STATS ? 16'd2 : 16'd0);
    @(posedge clk); #1;

    // Continuous reads starve a write until the limit forces it through.
    rdReqLevel = 1'b1;
    idleCycles(1);
    p = cyc;
    memQ.push_back('{p + 10, 16'h0010, 16'h0077});
    applyStimulus(1'b1, 16'h0010, 16'h0077, 1'b0);
    idleTo(p + 8);
    @(negedge clk);
    checkOutput("gntBeforeForce", 16'(rd_gnt), 16'h0001);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("forcedGnt", 16'(rd_gnt), 16'h0000);
    @(posedge clk); #1;
    idleCycles(2);

    // Fill past capacity while reads hog the port: fifth push is dropped.
    p = cyc;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) memQ.push_back('{p + 10 + 9 * i, 16'(i), 16'h00A0 + 16'(i)});
      applyStimulus(1'b1, 16'(i), 16'h00A0 + 16'(i), 1'b0);
    end
    @(negedge clk);
    checkOutput("overflowSet", 16'(overflow), 16'h0001);
    checkOutput("dropCountOne", {8'h00, drop_count}, STATS ? 16'd1 : 16'd0);
    @(posedge clk); #1;
    idleTo(p + 38);
    @(negedge clk);
    checkOutput("overflowSticky", 16'(overflow), 16'h0001);
    @(posedge clk); #1;

    // Drop coincident with clear keeps the flag; a push while full during a pop is kept.
    p = cyc;
    for (int i = 0; i < 4; i++) begin
      memQ.push_back('{p + 10 + 9 * i, 16'h0040 + 16'(i), 16'h00B0 + 16'(i)});
      applyStimulus(1'b1, 16'h0040 + 16'(i), 16'h00B0 + 16'(i), 1'b0);
    end
    applyStimulus(1'b1, 16'h0044, 16'h00B4, 1'b1);
    @(negedge clk);
    checkOutput("overflowClrDrop", 16'(overflow), 16'h0001);
    checkOutput("dropCountTwo", {8'h00, drop_count}, STATS ? 16'd2 : 16'd0);
    @(posedge clk); #1;
    idleTo(p + 9);
    memQ.push_back('{p + 46, 16'h0045, 16'h00B5});
    applyStimulus(1'b1, 16'h0045, 16'h00B5, 1'b0);
    idleTo(p + 47);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("overflowClear", 16'(overflow), 16'h0000);
    @(posedge clk); #1;
    rdReqLevel = 1'b0;
    idleCycles(4);

    // Reset during a pending write, then during reads with a coincident push.
    weBase = memWeCount;
    applyStimulus(1'b1, 16'h0030, 16'h0066, 1'b0);
    reset = 1'b0;
    idleCycles(2);
    reset = 1'b1;
    idleCycles(12);
    rdReqLevel = 1'b1;
    idleCycles(3);
    ebi_data_ready = 1'b1;
    ebi_address    = 16'h0020;
    ebi_data       = 16'h0055;
    reset          = 1'b0;
    @(posedge clk); #1;
    ebi_data_ready = 1'b0;
    rdReqLevel     = 1'b0;
    rd_req         = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idleCycles(12);
    @(negedge clk);
    checkOutput("noWriteAfterReset", 16'(memWeCount - weBase), 16'h0000);
    checkOutput("writeCountAfterReset", write_count, 16'h0000);
    checkOutput("dropCountAfterReset", {8'h00, drop_count}, 16'h0000);
    checkOutput("overflowAfterReset", 16'(overflow), 16'h0000);
    checkOutput("rdValidAfterReset", 16'(rd_valid), 16'h0000);
    @(posedge clk); #1;

    checkOutput("memQueueDrained", 16'(memQ.size()), 16'h0000);
    checkOutput("regQueueDrained", 16'(regQ.size()), 16'h0000);
    checkOutput("readQueueDrained", 16'(gntQ.size() + reQ.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
